// File: rtl/pmod_enc_pkg.sv
// -----------------------------------------------------------------------------
// pmod_enc_pkg
// Shared constants for the Pmod rotary-encoder AXI4-Lite slave: register
// word indices (ADDR[3:2]), CTRL/STATUS bit positions, the OKAY response
// code and a byte-lane merge helper used for WSTRB handling.
// No ports (package).
// -----------------------------------------------------------------------------
package pmod_enc_pkg;

    // Register word index taken from ADDR[3:2]
    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COUNT   = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_SW  = 0;
    localparam int STAT_A   = 1;
    localparam int STAT_B   = 2;
    localparam int STAT_DIR = 3;
    localparam int STAT_ERR = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pmod_enc_quad_dec.sv
// -----------------------------------------------------------------------------
// pmod_enc_quad_dec
// Two-flop synchronizers for the asynchronous encoder pins followed by a
// quadrature decoder that compares the synchronized {A,B} pair against its
// previous value.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   enc_a_i/enc_b_i/enc_sw_i  raw asynchronous encoder pins
//   a_o/b_o/sw_o           synchronized pin levels
//   step_o                 one-cycle pulse: exactly one of A/B changed
//   dir_o                  direction of that step (1 = up), valid with step_o
//   err_o                  one-cycle pulse: A and B changed together
// -----------------------------------------------------------------------------
module pmod_enc_quad_dec
    import pmod_enc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic enc_a_i,
    input  logic enc_b_i,
    input  logic enc_sw_i,
    output logic a_o,
    output logic b_o,
    output logic sw_o,
    output logic step_o,
    output logic dir_o,
    output logic err_o
);

    // Bit order inside the sync vectors: {sw, b, a}
    logic [2:0] sync_p0_q;
    logic [2:0] sync_p1_q;
    logic [1:0] ab_prev_q;   // {a, b} as seen one cycle earlier
    logic [1:0] ab_cur;
    logic [1:0] delta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0_q <= '0;
            sync_p1_q <= '0;
            ab_prev_q <= '0;
        end else begin
            // Stage p0 -> p1: metastability filter
            sync_p0_q <= {enc_sw_i, enc_b_i, enc_a_i};
            sync_p1_q <= sync_p0_q;
            // Stage p1 -> history for edge comparison
            ab_prev_q <= ab_cur;
        end
    end

    assign ab_cur = {sync_p1_q[0], sync_p1_q[1]};
    assign delta  = ab_prev_q ^ ab_cur;

    assign a_o    = sync_p1_q[0];
    assign b_o    = sync_p1_q[1];
    assign sw_o   = sync_p1_q[2];
    assign step_o = ^delta;
    assign err_o  = &delta;
    // Along 00->01->11->10->00 the new B always differs from the old A;
    // in the reverse direction they are equal.
    assign dir_o  = ab_prev_q[1] ^ ab_cur[0];

endmodule

// File: rtl/pmod_enc_axil_slave.sv
// -----------------------------------------------------------------------------
// pmod_enc_axil_slave
// AXI4-Lite slave exposing a Pmod quadrature encoder: CTRL, COUNT, STATUS,
// SCRATCH registers at 0x0/0x4/0x8/0xC.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXI_*               AXI4-Lite slave (AW, W, B, AR, R channels)
//   ENC_A, ENC_B, ENC_SW  asynchronous encoder pins
//   IRQ                   count-change interrupt (only with PMOD_ENC_IRQ_EN)
// Build option: define PMOD_ENC_IRQ_EN to add the IRQ output and CTRL.IRQ_EN.
// -----------------------------------------------------------------------------
module pmod_enc_axil_slave
    import pmod_enc_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            ENC_A,
    input  logic                            ENC_B,
    input  logic                            ENC_SW
`ifdef PMOD_ENC_IRQ_EN
    ,
    output logic                            IRQ
`endif
);

    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic        aw_done_q, w_done_q;
    logic [1:0]  awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;

    logic        ctrl_en_q;
    logic [31:0] count_q, count_d;
    logic [31:0] scratch_q;
    logic        err_q, dir_q;
`ifdef PMOD_ENC_IRQ_EN
    logic        ctrl_irq_en_q;
    logic        irq_q;
`endif

    logic        enc_a, enc_b, enc_sw, q_step, q_dir, q_err;
    logic        wr_fire, clr, step_en, ar_hs;
    logic        irq_en_bit;
    logic [31:0] rd_mux;

    pmod_enc_quad_dec u_dec (
        .clk_i    (ACLK),
        .rst_i    (ARESET),
        .enc_a_i  (ENC_A),
        .enc_b_i  (ENC_B),
        .enc_sw_i (ENC_SW),
        .a_o      (enc_a),
        .b_o      (enc_b),
        .sw_o     (enc_sw),
        .step_o   (q_step),
        .dir_o    (q_dir),
        .err_o    (q_err)
    );

`ifdef PMOD_ENC_IRQ_EN
    assign irq_en_bit = ctrl_irq_en_q;
    assign IRQ        = irq_q;
`else
    assign irq_en_bit = 1'b0;
`endif

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        // Both halves of the write are held; commit this cycle.
        wr_fire = aw_done_q & w_done_q;
        clr     = wr_fire && (awaddr_q == ADDR_CTRL) && wstrb_q[0] && wdata_q[CTRL_CLR];
        step_en = ctrl_en_q & q_step;
        ar_hs   = arready_q & S_AXI_ARVALID;

        count_d = count_q;
        if (clr)          count_d = '0;
        else if (step_en) count_d = q_dir ? count_q + 32'd1 : count_q - 32'd1;

        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            ADDR_CTRL:    rd_mux = {29'd0, irq_en_bit, 1'b0, ctrl_en_q};
            ADDR_COUNT:   rd_mux = count_q;
            ADDR_STATUS:  rd_mux = {27'd0, err_q, dir_q, enc_b, enc_a, enc_sw};
            default:      rd_mux = scratch_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            ctrl_en_q <= 1'b0;
            count_q   <= '0;
            scratch_q <= '0;
            err_q     <= 1'b0;
            dir_q     <= 1'b0;
`ifdef PMOD_ENC_IRQ_EN
            ctrl_irq_en_q <= 1'b0;
            irq_q         <= 1'b0;
`endif
        end else begin
            // Ready pulses for one cycle, and only when the channel is free.
            awready_q <= S_AXI_AWVALID && !awready_q && !aw_done_q && !bvalid_q;
            wready_q  <= S_AXI_WVALID  && !wready_q  && !w_done_q  && !bvalid_q;
            arready_q <= S_AXI_ARVALID && !arready_q && !rvalid_q;

            if (awready_q && S_AXI_AWVALID) begin
                aw_done_q <= 1'b1;
                awaddr_q  <= S_AXI_AWADDR[3:2];
            end
            if (wready_q && S_AXI_WVALID) begin
                w_done_q <= 1'b1;
                wdata_q  <= S_AXI_WDATA;
                wstrb_q  <= S_AXI_WSTRB;
            end

            if (wr_fire) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                case (awaddr_q)
                    ADDR_CTRL: begin
                        if (wstrb_q[0]) begin
                            ctrl_en_q <= wdata_q[CTRL_EN];
`ifdef PMOD_ENC_IRQ_EN
                            ctrl_irq_en_q <= wdata_q[CTRL_IRQ_EN];
`endif
                        end
                    end
                    ADDR_STATUS: begin
                        if (wstrb_q[0] && wdata_q[STAT_ERR]) err_q <= 1'b0;
                    end
                    ADDR_SCRATCH: scratch_q <= apply_wstrb(scratch_q, wdata_q, wstrb_q);
                    default: ;
                endcase
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            // Read data is sampled before any same-cycle write lands.
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end

            count_q <= count_d;
            if (step_en) dir_q <= q_dir;
            // A new error in the clearing cycle stays visible.
            if (ctrl_en_q && q_err) err_q <= 1'b1;

`ifdef PMOD_ENC_IRQ_EN
            if (ar_hs && S_AXI_ARADDR[3:2] == ADDR_STATUS) irq_q <= 1'b0;
            if (ctrl_irq_en_q && (count_d != count_q))     irq_q <= 1'b1;
`endif
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: doc/pmod_enc_axil_slave.md
PMOD_ENC_AXIL_SLAVE -- requirements
Module: pmod_enc_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, the AXI4-Lite byte address width.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports S_AXI_AWADDR/AWPROT/AWVALID/AWREADY (in, ADDR_W/3/1 bits; out, 1 bit): the AXI4-Lite write-address channel.
REQ-006 SHALL have ports S_AXI_WDATA/WSTRB/WVALID (in, 32/4/1 bits) and WREADY (out, 1 bit): the write-data channel.
REQ-007 SHALL have ports S_AXI_BRESP/BVALID (out, 2/1 bits) and BREADY (in, 1 bit): the write-response channel.
REQ-008 SHALL have ports S_AXI_ARADDR/ARPROT/ARVALID (in) and ARREADY (out): the read-address channel.
REQ-009 SHALL have ports S_AXI_RDATA/RRESP/RVALID (out, 32/2/1 bits) and RREADY (in, 1 bit): the read-data channel.
REQ-010 SHALL have ports ENC_A, ENC_B, ENC_SW, inputs, 1 bit each: asynchronous Pmod encoder pins.

Function
REQ-011 SHALL decode the register map on ADDR[3:2]: 0x0 CTRL (RW), 0x4 COUNT (RO), 0x8 STATUS (RO, except W1C bit 4), 0xC SCRATCH (RW).
REQ-012 SHALL define CTRL as: bit0 EN (counting enable); bit1 CLR (self-clearing, reads 0); bit2 IRQ_EN; remaining bits read 0.
REQ-013 SHALL define STATUS as: bit0 SW, bit1 A, bit2 B (synchronized), bit3 DIR (last step, 1 = up), bit4 ERR (sticky, W1C).
REQ-014 SHALL pass ENC_A/B/SW through a 2-flop synchronizer each, adding 2 cycles of latency before decoding.
REQ-015 SHALL decode quadrature on each change of the synchronized {A,B} pair when EN=1: sequence 00->01->11->10->00 is +1, the reverse is -1.
REQ-016 SHALL, when A and B change in the same cycle, leave COUNT unchanged and set ERR.
REQ-017 SHALL keep COUNT as 32-bit two's complement, wrapping modulo 2^32 (0xFFFFFFFF +1 -> 0; 0 -1 -> 0xFFFFFFFF).
REQ-018 SHALL, when CLR is written in the same cycle as a valid step, zero COUNT (CLR wins).
REQ-019 SHALL accept AW and W independently, each at most one outstanding, with xREADY high for one cycle per handshake.
REQ-020 SHALL perform the register write in the cycle after both AW and W are captured, applying WSTRB per byte lane.
REQ-021 SHALL assert BVALID with BRESP=OKAY together with that write, and hold it until BREADY; no new AW/W is accepted while BVALID=1.
REQ-022 SHALL accept AR only when RVALID=0, and drive RVALID with RDATA and RRESP=OKAY on the next cycle, held until RREADY.
REQ-023 SHALL ignore writes to read-only bits and still complete the write with OKAY.
REQ-024 SHALL, when a read and a write to the same register complete in the same cycle, return the pre-write value.

Reset
REQ-025 SHALL, while ARESET=1, clear CTRL, COUNT, SCRATCH, ERR, DIR, the synchronizers, and all handshake outputs (AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; RDATA = 0).
REQ-026 SHALL abandon any in-flight transaction on reset without issuing a response.

Configuration
REQ-027 SHALL, with PMOD_ENC_IRQ_EN defined, add output IRQ (1 bit, reset 0) that is set on any COUNT change while IRQ_EN=1 and cleared by a STATUS read.
REQ-028 SHALL, without PMOD_ENC_IRQ_EN defined, have no IRQ port, with CTRL bit2 reading 0.

Structure
REQ-029 SHALL place register offsets, CTRL/STATUS bit indices, and the OKAY response constant in the package pmod_enc_pkg.
REQ-030 SHALL implement quadrature sync/decode in the sub-module pmod_enc_quad_dec, which outputs step, dir, and err pulses.

Verification
REQ-031 SHALL verify: writing 0x1,0x2,0x3,0x4 to 0x0..0xC, then reading back -> CTRL=0x1, COUNT=0, STATUS=0x0 with pins low, SCRATCH=0x4.
REQ-032 SHALL verify: with EN=1, 4 forward A/B steps -> COUNT=4 and DIR=1; then 6 reverse steps -> COUNT=0xFFFFFFFE and DIR=0.
REQ-033 SHALL verify: A and B toggled together -> COUNT unchanged and STATUS bit4=1; writing 0x10 to STATUS -> bit4=0.
REQ-034 SHALL verify: W presented 3 cycles before AW, with BREADY held low for 5 cycles -> a single write, BVALID held, no second AWREADY.
REQ-035 SHALL verify: WSTRB=0b0010 with data 0xAABBCCDD to SCRATCH=0 -> reads back 0x0000CC00.
REQ-036 SHALL verify: ARESET pulsed during an outstanding read with RREADY low -> RVALID=0 the next cycle and COUNT=0.
